// File: rtl/bcd_pkg.sv
// Shared types and constants for the bcd_convert_7 double-dabble converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_CORR   = 4'd3;

    // Active-low gfedcba patterns for hex digits, entry 0 in the low slice.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_convert_7_if.sv
// Handshake and result bus between the controller and bcd_convert_7.
// Segment outputs exist only when BCD_SEG7_EN is defined.
interface bcd_convert_7_if #(
    parameter int unsigned WIDTH = 7
);
    logic [WIDTH-1:0] bin_in;
    logic             start;
    logic             ready;
    logic             busy;
    logic             done;
    logic [3:0]       bcd_hund;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
`ifdef BCD_SEG7_EN
    logic [6:0]       seg_hund;
    logic [6:0]       seg_tens;
    logic [6:0]       seg_ones;

    modport master (
        output bin_in, start,
        input  ready, busy, done, bcd_hund, bcd_tens, bcd_ones,
               seg_hund, seg_tens, seg_ones
    );
    modport slave (
        input  bin_in, start,
        output ready, busy, done, bcd_hund, bcd_tens, bcd_ones,
               seg_hund, seg_tens, seg_ones
    );
`else
    modport master (
        output bin_in, start,
        input  ready, busy, done, bcd_hund, bcd_tens, bcd_ones
    );
    modport slave (
        input  bin_in, start,
        output ready, busy, done, bcd_hund, bcd_tens, bcd_ones
    );
`endif
endinterface

// File: rtl/seg7_decode.sv
// One BCD/hex digit to active-low gfedcba segments, with forced blanking.
module seg7_decode
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = blank ? SEG_BLANK : SEG_LUT[digit];
    end

endmodule

// File: rtl/bcd_convert_7.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional 7-segment outputs with leading-zero blanking under BCD_SEG7_EN.
module bcd_convert_7
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 7,
    parameter int unsigned DIGITS = 3
) (
    input logic              CLK,
    input logic              RST,
    bcd_convert_7_if.slave   bus
);

    localparam int unsigned SCR_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned CAT_W = SCR_W + WIDTH;

    state_t             state;
    logic [WIDTH-1:0]   bin_sr;
    logic [SCR_W-1:0]   scr;
    logic [CNT_W-1:0]   cnt;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         hund_q;
    logic [3:0]         tens_q;
    logic [3:0]         ones_q;

    logic [SCR_W-1:0]   corr;
    logic [CAT_W-1:0]   cat_shift;
    logic [SCR_W-1:0]   scr_nxt;
    logic [WIDTH-1:0]   bin_nxt;

    // One double-dabble step: correct every digit >= 5, then shift {scratch, binary}.
    always_comb begin
        corr = scr;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scr[4*i +: 4] >= ADD3_THRESH) begin
                corr[4*i +: 4] = scr[4*i +: 4] + ADD3_CORR;
            end
        end
        cat_shift = {corr, bin_sr} << 1;
        scr_nxt   = cat_shift[CAT_W-1:WIDTH];
        bin_nxt   = cat_shift[WIDTH-1:0];
    end

`ifdef BCD_SEG7_EN
    logic [6:0] seg_hund_c;
    logic [6:0] seg_tens_c;
    logic [6:0] seg_ones_c;
    logic [6:0] seg_hund_q;
    logic [6:0] seg_tens_q;
    logic [6:0] seg_ones_q;
    logic       hund_zero;
    logic       tens_zero;

    assign hund_zero = (scr_nxt[11:8] == 4'd0);
    assign tens_zero = (scr_nxt[7:4] == 4'd0);

    seg7_decode u_seg_hund (.digit(scr_nxt[11:8]), .blank(hund_zero),             .seg_c(seg_hund_c));
    seg7_decode u_seg_tens (.digit(scr_nxt[7:4]),  .blank(hund_zero & tens_zero), .seg_c(seg_tens_c));
    seg7_decode u_seg_ones (.digit(scr_nxt[3:0]),  .blank(1'b0),                  .seg_c(seg_ones_c));

    // Segment registers load together with the digit registers on the edge entering DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_hund_q <= SEG_BLANK;
            seg_tens_q <= SEG_BLANK;
            seg_ones_q <= SEG_BLANK;
        end else if (state == SHIFT && cnt == CNT_W'(1)) begin
            seg_hund_q <= seg_hund_c;
            seg_tens_q <= seg_tens_c;
            seg_ones_q <= seg_ones_c;
        end
    end

    assign bus.seg_hund = seg_hund_q;
    assign bus.seg_tens = seg_tens_q;
    assign bus.seg_ones = seg_ones_q;
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scr     <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= SHIFT;
                        bin_sr  <= bus.bin_in;
                        scr     <= '0;
                        cnt     <= CNT_W'(WIDTH);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    scr    <= scr_nxt;
                    bin_sr <= bin_nxt;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        hund_q <= scr_nxt[11:8];
                        tens_q <= scr_nxt[7:4];
                        ones_q <= scr_nxt[3:0];
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_hund = hund_q;
    assign bus.bcd_tens = tens_q;
    assign bus.bcd_ones = ones_q;

endmodule
